// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe: pipelined (a +/- b) mod P with the carry/borrow chains split over LEVEL stages.
// Both candidate results are built segment by segment; the last stage picks one by its final carries.
module mod_addsub_pipe #(
    parameter logic [511:0] P        = 512'd97,
    parameter int           BITS     = $clog2(P),
    parameter int           CTL_BITS = 8,
    parameter int           LEVEL    = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [BITS-1:0]     i_dat_a,
    input  logic [BITS-1:0]     i_dat_b,
    input  logic                i_sub,
    input  logic                i_val,
    input  logic [CTL_BITS-1:0] i_ctl,
    output logic                o_rdy,
    output logic                o_val,
    input  logic                i_rdy,
    output logic [BITS-1:0]     o_dat,
    output logic [CTL_BITS-1:0] o_ctl
);
    localparam int SEG = (BITS + LEVEL - 1) / LEVEL;
    localparam int DAT_BITS = LEVEL * SEG;
    localparam int L = LEVEL - 1;
    localparam logic [DAT_BITS-1:0] PD = DAT_BITS'(P);
    localparam logic [DAT_BITS-1:0] MSK = DAT_BITS'({SEG{1'b1}});

    if (LEVEL < 1 || LEVEL > BITS) begin : g_bad_level
        $error("mod_addsub_pipe: LEVEL=%0d must lie in [1, BITS=%0d]", LEVEL, BITS);
    end
    if (P[0] == 1'b0 || P < 3) begin : g_bad_mod
        $error("mod_addsub_pipe: P must be odd and greater than 2");
    end

    logic [LEVEL-1:0] val_q, sub_q, c0_q, c1_q, ld;
    logic [LEVEL-1:0] val_d, sub_d, c0_d, c1_d;
    logic [DAT_BITS-1:0] r0_q [LEVEL];
    logic [DAT_BITS-1:0] r1_q [LEVEL];
    logic [DAT_BITS-1:0] r0_d [LEVEL];
    logic [DAT_BITS-1:0] r1_d [LEVEL];
    logic [CTL_BITS-1:0] ctl_q [LEVEL];
    logic [CTL_BITS-1:0] ctl_d [LEVEL];

    // r0/r1 enter holding a/b; each stage overwrites its own segment with the two candidates.
    for (genvar k = 0; k < LEVEL; k++) begin : g_st
        logic s_in, c0_in, c1_in;
        logic [DAT_BITS-1:0] r0_in, r1_in;
        logic [SEG:0] x, y, s, t, p;
        if (k == 0) begin : g_src
            assign val_d[k] = i_val;
            assign s_in = i_sub;
            assign c0_in = 1'b0;
            assign c1_in = 1'b0;
            assign r0_in = DAT_BITS'(i_dat_a);
            assign r1_in = DAT_BITS'(i_dat_b);
            assign ctl_d[k] = i_ctl;
        end else begin : g_src
            assign val_d[k] = val_q[k-1];
            assign s_in = sub_q[k-1];
            assign c0_in = c0_q[k-1];
            assign c1_in = c1_q[k-1];
            assign r0_in = r0_q[k-1];
            assign r1_in = r1_q[k-1];
            assign ctl_d[k] = ctl_q[k-1];
        end
        assign x = {1'b0, r0_in[k*SEG +: SEG]};
        assign y = {1'b0, r1_in[k*SEG +: SEG]};
        assign p = {1'b0, PD[k*SEG +: SEG]};
        assign s = s_in ? x - y - {{SEG{1'b0}}, c0_in} : x + y + {{SEG{1'b0}}, c0_in};
        assign t = s_in ? {1'b0, s[SEG-1:0]} + p + {{SEG{1'b0}}, c1_in}
                        : {1'b0, s[SEG-1:0]} - p - {{SEG{1'b0}}, c1_in};
        assign sub_d[k] = s_in;
        assign c0_d[k] = s[SEG];
        assign c1_d[k] = t[SEG];
        assign r0_d[k] = (r0_in & ~(MSK << (k * SEG))) | (DAT_BITS'(s[SEG-1:0]) << (k * SEG));
        assign r1_d[k] = (r1_in & ~(MSK << (k * SEG))) | (DAT_BITS'(t[SEG-1:0]) << (k * SEG));
        // a stage may load when any stage from here to the output is empty, or the sink takes data
        assign ld[k] = i_rdy | (|(~val_q >> k));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            val_q <= '0;
            sub_q <= '0;
            c0_q <= '0;
            c1_q <= '0;
            for (int k = 0; k < LEVEL; k++) begin
                r0_q[k] <= '0;
                r1_q[k] <= '0;
                ctl_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LEVEL; k++) begin
                if (ld[k]) begin
                    val_q[k] <= val_d[k];
                    if (val_d[k]) begin
                        sub_q[k] <= sub_d[k];
                        c0_q[k] <= c0_d[k];
                        c1_q[k] <= c1_d[k];
                        r0_q[k] <= r0_d[k];
                        r1_q[k] <= r1_d[k];
                        ctl_q[k] <= ctl_d[k];
                    end
                end
            end
        end
    end

    assign o_val = val_q[L];
    assign o_ctl = ctl_q[L];
    assign o_rdy = ld[0];
    assign o_dat = BITS'((sub_q[L] ? c0_q[L] : (c0_q[L] | ~c1_q[L])) ? r1_q[L] : r0_q[L]);
endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb_mod_addsub_pipe: directed P=97 checks plus a randomized BLS12-381 stream against a
// plain-arithmetic (a +/- b) mod P scoreboard.
module tb_mod_addsub_pipe;
    localparam logic [383:0] PW = 384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
    localparam int WL = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] a, b, dat;
    logic sub, val, ordy, oval, irdy;
    logic [7:0] ctl, octl;
    mod_addsub_pipe #(.P(512'd97), .BITS(7), .CTL_BITS(8), .LEVEL(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_dat_a(a), .i_dat_b(b), .i_sub(sub), .i_val(val),
        .i_ctl(ctl), .o_rdy(ordy), .o_val(oval), .i_rdy(irdy), .o_dat(dat), .o_ctl(octl));

    logic [380:0] wa, wb, wdat;
    logic wsub, wval, wordy, woval, wirdy;
    logic [7:0] wctl, woctl;
    mod_addsub_pipe #(.P(512'(PW)), .BITS(381), .CTL_BITS(8), .LEVEL(WL)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_dat_a(wa), .i_dat_b(wb), .i_sub(wsub), .i_val(wval),
        .i_ctl(wctl), .o_rdy(wordy), .o_val(woval), .i_rdy(wirdy), .o_dat(wdat), .o_ctl(woctl));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] ref_mod(input logic [383:0] x, input logic [383:0] y,
                                             input logic [383:0] p, input logic s);
        logic [384:0] t;
        t = s ? {1'b0, x} + {1'b0, p} - {1'b0, y} : {1'b0, x} + {1'b0, y};
        if (t >= {1'b0, p}) t = t - {1'b0, p};
        return t[383:0];
    endfunction

    function automatic logic [380:0] rnd_fe();
        logic [383:0] r;
        int v;
        v = int'($urandom_range(15));
        if (v == 0) return '0;
        if (v == 1) return 381'(PW - 1);
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
        r[383:381] = 3'b0;
        if (r >= PW) r = r - PW;
        return r[380:0];
    endfunction

    logic [383:0] eq_d[$];
    logic [7:0] eq_c[$];
    int ta[5] = '{5, 96, 0, 96, 0};
    int tb[5] = '{9, 0, 0, 96, 0};
    int ts[5] = '{1, 1, 1, 0, 0};
    int te[5] = '{93, 96, 0, 95, 0};

    initial begin
        int sent, got, infl, cyc, seen;
        logic acc, del, pv;
        logic [6:0] pdat;
        logic [7:0] pctl;
        a = '0; b = '0; sub = 0; val = 0; ctl = '0; irdy = 1;
        wa = '0; wb = '0; wsub = 0; wval = 0; wctl = '0; wirdy = 1;
        #1 rst = 1;
        #2;
        check("rst_val", oval, 0);
        check("rst_dat", dat, 0);
        check("rst_ctl", octl, 0);
        check("rst_rdy", ordy, 1);
        @(negedge clk);
        rst = 0;
        a = 50; b = 60; sub = 0; ctl = 8'ha5; val = 1;
        @(negedge clk);
        val = 0;
        check("lat1_val", oval, 0);
        @(negedge clk);
        check("lat2_val", oval, 0);
        @(negedge clk);
        check("lat3_val", oval, 1);
        check("lat3_dat", dat, 13);
        check("lat3_ctl", octl, 8'ha5);
        for (int c = 0; c < 8; c++) begin
            if (c >= 1 && c < 3) check("b2b_idle", oval, 0);
            if (c >= 3) begin
                check("b2b_val", oval, 1);
                check("b2b_dat", dat, 384'(te[c-3]));
                check("b2b_ctl", octl, 384'(16 + c - 3));
            end
            val = c < 5;
            if (c < 5) begin
                a = 7'(ta[c]); b = 7'(tb[c]); sub = ts[c][0]; ctl = 8'(16 + c);
            end
            @(negedge clk);
        end
        sent = 0; got = 0; infl = 0; cyc = 0; pv = 0; pdat = '0; pctl = '0;
        while ((sent < 20 || got < 20) && cyc < 400) begin
            irdy = (cyc % 3 == 0);
            val = sent < 20;
            a = 7'($urandom_range(96)); b = 7'($urandom_range(96)); sub = 1'($urandom);
            ctl = 8'(sent);
            #1;
            if (pv) begin
                check("bp_hold_val", oval, 1);
                check("bp_hold_dat", dat, pdat);
                check("bp_hold_ctl", octl, pctl);
            end
            check("bp_rdy", ordy, !(infl == 3 && !irdy));
            acc = val && ordy;
            del = oval && irdy;
            if (del) begin
                check("bp_extra", eq_d.size() > 0, 1);
                if (eq_d.size() > 0) begin
                    check("bp_dat", dat, eq_d.pop_front());
                    check("bp_ctl", octl, eq_c.pop_front());
                end
                got++;
            end
            if (acc) begin
                eq_d.push_back(ref_mod(384'(a), 384'(b), 384'd97, sub));
                eq_c.push_back(ctl);
                sent++;
            end
            infl = infl + int'(acc) - int'(del);
            pv = oval && !irdy;
            pdat = dat;
            pctl = octl;
            cyc++;
            @(negedge clk);
        end
        val = 0;
        check("bp_got", 384'(got), 20);
        irdy = 0;
        for (int i = 0; i < 3; i++) begin
            val = 1; a = 50; b = 60; sub = 0; ctl = 8'(8'h30 + i);
            @(negedge clk);
        end
        val = 0;
        check("rst_pre_val", oval, 1);
        check("rst_pre_rdy", ordy, 0);
        #2 rst = 1;
        #1;
        check("rst_mid_val", oval, 0);
        check("rst_mid_dat", dat, 0);
        check("rst_mid_ctl", octl, 0);
        check("rst_mid_rdy", ordy, 1);
        #1 rst = 0;
        irdy = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen += int'(oval);
        end
        check("rst_discard", 384'(seen), 0);
        eq_d.delete();
        eq_c.delete();
        sent = 0; infl = 0;
        for (int c = 0; c < 4000; c++) begin
            wirdy = $urandom_range(3) != 0;
            wval = $urandom_range(3) != 0;
            wa = rnd_fe(); wb = rnd_fe(); wsub = 1'($urandom); wctl = 8'(sent);
            #1;
            check("w_rdy", wordy, !(infl == WL && !wirdy));
            acc = wval && wordy;
            del = woval && wirdy;
            if (del) begin
                check("w_extra", eq_d.size() > 0, 1);
                if (eq_d.size() > 0) begin
                    check("w_dat", wdat, eq_d.pop_front());
                    check("w_ctl", woctl, eq_c.pop_front());
                end
            end
            if (acc) begin
                eq_d.push_back(ref_mod(384'(wa), 384'(wb), PW, wsub));
                eq_c.push_back(wctl);
                sent++;
            end
            infl = infl + int'(acc) - int'(del);
            @(negedge clk);
        end
        wval = 0;
        wirdy = 1;
        for (int c = 0; c < 50 && eq_d.size() > 0; c++) begin
            #1;
            if (woval) begin
                check("w_drain_dat", wdat, eq_d.pop_front());
                check("w_drain_ctl", woctl, eq_c.pop_front());
            end
            @(negedge clk);
        end
        check("w_left", 384'(eq_d.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
